// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues one icache request at a time, holds the fetched
// instruction (or a misaligned-PC exception marker) in a register until ID consumes it.
module if_fetch_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] PREIF_PC,
  input  logic        PREIF_Valid,
  output logic        PREIF_Ready,
  input  logic        IF_Flush,
  input  logic        ID_Ready,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_addr_ok,
  input  logic        ibus_data_ok,
  input  logic [31:0] ibus_rdata,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        adel_q, adel_d;
  logic        req, ready;
  logic        aligned, issue_ok;

  assign aligned  = (PREIF_PC[1:0] == 2'b00);
  assign issue_ok = PREIF_Valid & ~IF_Flush;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    out_pc_d = out_pc_q;
    instr_d  = instr_q;
    adel_d   = adel_q;
    req      = 1'b0;
    ready    = 1'b0;
    case (state_q)
      StIdle: begin
        req = issue_ok & aligned;
        if (req && ibus_addr_ok) begin
          ready   = 1'b1;
          pc_d    = PREIF_PC;
          state_d = StWait;
        end else if (issue_ok && !aligned) begin
          // Misaligned PC never reaches the bus; it is reported to ID as an AdEL fetch.
          ready    = 1'b1;
          valid_d  = 1'b1;
          out_pc_d = PREIF_PC;
          instr_d  = 32'h0;
          adel_d   = 1'b1;
          state_d  = StHold;
        end
      end
      StWait: begin
        if (IF_Flush) begin
          state_d = ibus_data_ok ? StIdle : StDiscard;
        end else if (ibus_data_ok) begin
          valid_d  = 1'b1;
          out_pc_d = pc_q;
          instr_d  = ibus_rdata;
          adel_d   = 1'b0;
          state_d  = StHold;
        end
      end
      StDiscard: begin
        if (ibus_data_ok) state_d = StIdle;
      end
      StHold: begin
        req = ID_Ready & issue_ok & aligned;
        if (IF_Flush) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (ID_Ready) begin
          if (req && ibus_addr_ok) begin
            ready   = 1'b1;
            pc_d    = PREIF_PC;
            valid_d = 1'b0;
            state_d = StWait;
          end else if (issue_ok && !aligned) begin
            ready    = 1'b1;
            out_pc_d = PREIF_PC;
            instr_d  = 32'h0;
            adel_d   = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      pc_q     <= 32'h0;
      valid_q  <= 1'b0;
      out_pc_q <= 32'h0;
      instr_q  <= 32'h0;
      adel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      out_pc_q <= out_pc_d;
      instr_q  <= instr_d;
      adel_q   <= adel_d;
    end
  end

  // Handshake outputs are forced low while reset is held, independent of pre-IF inputs.
  assign ibus_req    = req & resetn;
  assign PREIF_Ready = ready & resetn;
  assign ibus_addr   = PREIF_PC;
  assign IF_Valid    = valid_q;
  assign IF_PC       = out_pc_q;
  assign IF_Instr    = instr_q;
  assign IF_AdEL     = adel_q;

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-002 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port PREIF_PC  in  32  next fetch address from pre-IF.
REQ-004 SHALL have port PREIF_Valid  in  1  PREIF_PC valid this cycle.
REQ-005 SHALL have port PREIF_Ready  out  1  PREIF_PC accepted this cycle; pre-IF advances.
REQ-006 SHALL have port IF_Flush  in  1  kill in-flight/held fetch (mispredict, exception, refetch).
REQ-007 SHALL have port ID_Ready  in  1  ID accepts held instruction this cycle.
REQ-008 SHALL have port ibus_req  out  1  instruction bus request.
REQ-009 SHALL have port ibus_addr  out  32  request address; equals PREIF_PC.
REQ-010 SHALL have port ibus_addr_ok  in  1  request accepted by icache.
REQ-011 SHALL have port ibus_data_ok  in  1  read data valid.
REQ-012 SHALL have port ibus_rdata  in  32  read data.
REQ-013 SHALL have ports IF_Valid out 1, IF_PC out 32, IF_Instr out 32, IF_AdEL out 1  registered fetch result to ID.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, HOLD, DISCARD; at most one outstanding bus request.
REQ-015 IDLE: SHALL assert ibus_req = PREIF_Valid & ~IF_Flush & (PREIF_PC[1:0]==0).
REQ-016 IDLE: ibus_req & ibus_addr_ok SHALL assert PREIF_Ready combinationally and move to WAIT, latching PC internally.
REQ-017 IDLE: PREIF_Valid & ~IF_Flush & PREIF_PC[1:0]!=0 SHALL assert PREIF_Ready, keep ibus_req=0, load output reg (PC, Instr=0, AdEL=1, Valid=1), go HOLD.
REQ-018 WAIT: ibus_req=0; ibus_data_ok & ~IF_Flush SHALL load output reg (latched PC, ibus_rdata, AdEL=0, Valid=1), go HOLD.
REQ-019 WAIT: IF_Flush & ibus_data_ok same cycle SHALL drop data, go IDLE; IF_Flush without data_ok SHALL go DISCARD.
REQ-020 DISCARD: ibus_req=0, PREIF_Ready=0; ibus_data_ok SHALL drop data and go IDLE; IF_Flush here has no further effect.
REQ-021 HOLD: IF_Valid=1 and output reg stable until consumed; ibus_req = ID_Ready & PREIF_Valid & ~IF_Flush & aligned.
REQ-022 HOLD: ID_Ready & ibus_req & ibus_addr_ok SHALL assert PREIF_Ready, go WAIT, IF_Valid=0 next cycle.
REQ-023 HOLD: ID_Ready without new acceptance SHALL go IDLE, IF_Valid=0 next cycle; misaligned PC with ID_Ready SHALL follow REQ-017 and stay HOLD with new contents.
REQ-024 HOLD: IF_Flush SHALL clear IF_Valid next cycle and go IDLE regardless of ID_Ready.
REQ-025 PREIF_Ready SHALL never assert when IF_Flush=1.
REQ-026 ibus_addr SHALL equal PREIF_PC in all states; ibus_req SHALL not depend on ibus_addr_ok.
REQ-027 Best-case throughput: one instruction per 2 cycles (addr_ok cycle, data_ok next cycle, consumed in HOLD while next request issues).

Reset
REQ-028 resetn=0 SHALL asynchronously force state IDLE, IF_Valid=0, IF_PC=0, IF_Instr=0, IF_AdEL=0, latched PC=0.
REQ-029 Reset during WAIT/DISCARD SHALL abandon the outstanding request; environment resets icache simultaneously, no stale data_ok expected.
REQ-030 ibus_req and PREIF_Ready SHALL be 0 while resetn=0.

Verification
REQ-031 Normal fetch: PC=0xBFC00000, addr_ok cycle 0, data_ok cycle 1 rdata=0x3C080001, ID_Ready=1 -> cycle 2 IF_Valid=1, IF_PC=0xBFC00000, IF_Instr=0x3C080001, next request issued same cycle.
REQ-032 Flush during miss: request 0x80000100 accepted, IF_Flush cycle 2, data_ok cycle 5 -> state DISCARD cycles 3-5, IF_Valid stays 0, no ibus_req until cycle 6.
REQ-033 Flush with data_ok same cycle: WAIT, IF_Flush=1 & data_ok=1 -> IDLE next cycle, IF_Valid=0, PREIF_Ready=0 that cycle.
REQ-034 ID stall: HOLD with ID_Ready=0 for 4 cycles, PREIF_Valid=1 -> ibus_req=0, IF_PC/IF_Instr constant; ID_Ready=1 with addr_ok -> PREIF_Ready=1, WAIT.
REQ-035 Misaligned PC=0x80000102 in IDLE -> no ibus_req, PREIF_Ready=1, next cycle IF_Valid=1, IF_AdEL=1, IF_Instr=0, IF_PC=0x80000102.
REQ-036 Async reset asserted mid-WAIT -> outputs zero immediately without clock edge; after release first request issues from IDLE.
